// File: rtl/sms_trigger_pkg.sv
// Shared definitions for the SMS trigger card library.
//   pu_resolve  : maps a card-level pull-up net bit to a clean level
//                 (1 or z -> 1, 0 or x -> 0)
//   filt_width  : counter width needed to count up to a filter depth
//   MAX_FILTER  : deepest input filter the channel supports
//   pin_e       : index of each per-channel input inside the pin vectors
package sms_trigger_pkg;

   localparam int MAX_FILTER = 15;
   localparam int NUM_PINS   = 3;

   typedef enum logic [1:0] {
      PIN_ON  = 2'd0,
      PIN_OFF = 2'd1,
      PIN_TOG = 2'd2
   } pin_e;

   // An undriven net floats high through the card pull-up, while an
   // unknown level is treated as a pulled-down (active) input.
   // 0 and 1 are tested first, so a two-state simulator resolves them correctly.
   function automatic logic pu_resolve(input logic v);
      if (v === 1'b0)
         return 1'b0;
      else if (v === 1'b1)
         return 1'b1;
      else if (v === 1'bz)
         return 1'b1;
      else
         return 1'b0;
   endfunction

   function automatic int filt_width(input int fc);
      return (fc < 1) ? 1 : $clog2(fc + 1);
   endfunction

endpackage

// File: rtl/sms_trigger_channel.sv
// One set/reset trigger circuit.
// Each of on_n/off_n/tog_n is resolved from its pull-up net, passed
// through a SYNC_STAGES-deep synchroniser and a FILTER_CYCLES glitch
// filter, then drives a prioritised state update.
//   clk           : card clock
//   r             : asynchronous active-low master reset
//   on_n / off_n  : force state to 1 / 0 (active low)
//   tog_n         : falling edge inverts state when TOGGLE_EN is set
//   q / q_n       : trigger state and its complement
//   chg           : high for the single cycle after q changes
module sms_trigger_channel
   import sms_trigger_pkg::*;
#(
   parameter bit TOGGLE_EN     = 1'b0,
   parameter bit RESET_VAL     = 1'b1,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 0
) (
   input  logic clk,
   input  logic r,
   input  logic on_n,
   input  logic off_n,
   input  logic tog_n,
   output logic q,
   output logic q_n,
   output logic chg
);

   localparam int CW = filt_width(FILTER_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES);

   logic [NUM_PINS-1:0]    pin_lvl;
   logic [SYNC_STAGES-1:0] sync_q [NUM_PINS];
   logic [CW-1:0]          cnt_q  [NUM_PINS];
   logic [NUM_PINS-1:0]    sample;
   logic [NUM_PINS-1:0]    acc_q;
   logic [NUM_PINS-1:0]    take;
   logic [NUM_PINS-1:0]    eff;
   logic                   tog_prev_q;
   logic                   q_next;

   assign pin_lvl = {pu_resolve(tog_n), pu_resolve(off_n), pu_resolve(on_n)};

   // The accepted level is used in the same cycle the filter decides to
   // accept a new level, so FILTER_CYCLES = 0 degenerates to a wire from
   // the synchroniser output and adds no latency.
   always_comb begin
      sample = '0;
      take   = '0;
      eff    = '0;
      for (int p = 0; p < NUM_PINS; p++) begin
         sample[p] = sync_q[p][SYNC_STAGES-1];
         take[p]   = (sample[p] != acc_q[p]) && (cnt_q[p] == CNT_LAST);
         eff[p]    = take[p] ? sample[p] : acc_q[p];
      end
   end

   // Synchronisers shift in the resolved pin level; the filter counter
   // counts consecutive samples that disagree with the accepted level and
   // restarts whenever a sample agrees or a new level has been accepted.
   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         for (int p = 0; p < NUM_PINS; p++) begin
            sync_q[p] <= '1;
            cnt_q[p]  <= '0;
         end
         acc_q <= '1;
      end else begin
         for (int p = 0; p < NUM_PINS; p++) begin
            sync_q[p] <= {sync_q[p][SYNC_STAGES-2:0], pin_lvl[p]};
            if ((sample[p] == acc_q[p]) || take[p])
               cnt_q[p] <= '0;
            else
               cnt_q[p] <= cnt_q[p] + 1'b1;
         end
         acc_q <= eff;
      end
   end

   // Set beats reset beats toggle. A toggle edge seen while a force input
   // is active is lost, because the edge detector still advances.
   always_comb begin
      q_next = q;
      if (!eff[PIN_ON])
         q_next = 1'b1;
      else if (!eff[PIN_OFF])
         q_next = 1'b0;
      else if (TOGGLE_EN && tog_prev_q && !eff[PIN_TOG])
         q_next = ~q;
   end

   // State, change strobe and the previous toggle level for edge detection.
   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         q          <= RESET_VAL;
         chg        <= 1'b0;
         tog_prev_q <= 1'b1;
      end else begin
         q          <= q_next;
         chg        <= (q_next != q);
         tog_prev_q <= eff[PIN_TOG];
      end
   end

   assign q_n = ~q;

endmodule

// File: rtl/sms_card_trigger_bank.sv
// Bank of CHANNELS independent set/reset triggers.
// The top level only slices the pin vectors across per-channel instances.
//   clk    : card clock
//   r      : asynchronous active-low master reset
//   on_n   : per-channel force-to-1, active low
//   off_n  : per-channel force-to-0, active low
//   tog_n  : per-channel toggle, falling edge, channels in TOGGLE_MASK only
//   q/q_n  : trigger states and complements
//   chg    : one-cycle strobe per channel when q changes
module sms_card_trigger_bank
   import sms_trigger_pkg::*;
#(
   parameter int                  CHANNELS      = 2,
   parameter logic [CHANNELS-1:0] TOGGLE_MASK   = '0,
   parameter logic [CHANNELS-1:0] RESET_STATE   = '1,
   parameter int                  SYNC_STAGES   = 2,
   parameter int                  FILTER_CYCLES = 0
) (
   input  logic                clk,
   input  logic                r,
   input  logic [CHANNELS-1:0] on_n,
   input  logic [CHANNELS-1:0] off_n,
   input  logic [CHANNELS-1:0] tog_n,
   output logic [CHANNELS-1:0] q,
   output logic [CHANNELS-1:0] q_n,
   output logic [CHANNELS-1:0] chg
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("sms_card_trigger_bank: SYNC_STAGES must be 2..4");
   end
   if (FILTER_CYCLES < 0 || FILTER_CYCLES > MAX_FILTER) begin : g_bad_filter
      $error("sms_card_trigger_bank: FILTER_CYCLES must be 0..15");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      sms_trigger_channel #(
         .TOGGLE_EN    (TOGGLE_MASK[i]),
         .RESET_VAL    (RESET_STATE[i]),
         .SYNC_STAGES  (SYNC_STAGES),
         .FILTER_CYCLES(FILTER_CYCLES)
      ) u_ch (
         .clk  (clk),
         .r    (r),
         .on_n (on_n[i]),
         .off_n(off_n[i]),
         .tog_n(tog_n[i]),
         .q    (q[i]),
         .q_n  (q_n[i]),
         .chg  (chg[i])
      );
   end

endmodule

// File: tb/tb_sms_card_trigger_bank.sv
// Bench for sms_card_trigger_bank: two instances share the same pins,
// one unfiltered with toggle on channel 0 only, one with a 3-sample filter
// and toggle on both channels. A history/window reference model predicts
// q, q_n and chg on every edge.
module tb_sms_card_trigger_bank;

   localparam int         SYNC_A = 2, FC_A = 0;
   localparam logic [1:0] MASK_A = 2'b01, RS_A = 2'b11;
   localparam int         SYNC_B = 2, FC_B = 3;
   localparam logic [1:0] MASK_B = 2'b11, RS_B = 2'b10;

   logic       clk = 1'b0;
   logic       r;
   logic [1:0] on_n, off_n, tog_n;
   logic [1:0] q0, qn0, chg0, q1, qn1, chg1;

   int checks = 0;
   int errors = 0;

   int         syncN [2] = '{SYNC_A, SYNC_B};
   int         fcN   [2] = '{FC_A, FC_B};
   logic [1:0] maskN [2] = '{MASK_A, MASK_B};
   logic [1:0] rsN   [2] = '{RS_A, RS_B};

   // Pin history per channel*3+pin, sample history per dut*6+channel*3+pin.
   bit         pinHist  [6][$];
   bit         sampHist [12][$];
   bit         acc      [12];
   bit         togPrev  [4];
   logic [1:0] mq       [2];
   logic [1:0] mchg     [2];

   sms_card_trigger_bank #(
      .CHANNELS(2), .TOGGLE_MASK(MASK_A), .RESET_STATE(RS_A),
      .SYNC_STAGES(SYNC_A), .FILTER_CYCLES(FC_A)
   ) dut_a (
      .clk(clk), .r(r), .on_n(on_n), .off_n(off_n), .tog_n(tog_n),
      .q(q0), .q_n(qn0), .chg(chg0)
   );

   sms_card_trigger_bank #(
      .CHANNELS(2), .TOGGLE_MASK(MASK_B), .RESET_STATE(RS_B),
      .SYNC_STAGES(SYNC_B), .FILTER_CYCLES(FC_B)
   ) dut_b (
      .clk(clk), .r(r), .on_n(on_n), .off_n(off_n), .tog_n(tog_n),
      .q(q1), .q_n(qn1), .chg(chg1)
   );

   always #5 clk = ~clk;

   function automatic bit pinVal(input int c, input int p);
      case (p)
         0:       return on_n[c];
         1:       return off_n[c];
         default: return tog_n[c];
      endcase
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 6; i++) pinHist[i].delete();
      for (int i = 0; i < 12; i++) begin
         sampHist[i].delete();
         acc[i] = 1'b1;
      end
      for (int i = 0; i < 4; i++) togPrev[i] = 1'b1;
      for (int d = 0; d < 2; d++) begin
         mq[d]   = rsN[d];
         mchg[d] = 2'b00;
      end
   endtask

   // A pin level seen at an edge reaches the state logic SYNC edges later;
   // a new level is accepted once the last FC+1 samples all disagree with
   // the currently accepted one.
   task automatic modelEdge();
      int  n, m, idx, sidx;
      bit  s, allDiff, oldQ, newQ;
      bit  eff [3];
      for (int c = 0; c < 2; c++)
         for (int p = 0; p < 3; p++)
            pinHist[c*3+p].push_back(pinVal(c, p));
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 3; p++) begin
               idx  = c*3 + p;
               sidx = d*6 + idx;
               n    = pinHist[idx].size();
               s    = (n - 1 - syncN[d] >= 0) ? pinHist[idx][n-1-syncN[d]] : 1'b1;
               sampHist[sidx].push_back(s);
               m       = sampHist[sidx].size();
               allDiff = (m >= fcN[d] + 1);
               if (allDiff)
                  for (int j = 0; j <= fcN[d]; j++)
                     if (sampHist[sidx][m-1-j] == acc[sidx]) allDiff = 1'b0;
               if (allDiff) acc[sidx] = ~acc[sidx];
               eff[p] = acc[sidx];
            end
            oldQ = mq[d][c];
            newQ = oldQ;
            if (!eff[0])
               newQ = 1'b1;
            else if (!eff[1])
               newQ = 1'b0;
            else if (maskN[d][c] && togPrev[d*2+c] && !eff[2])
               newQ = ~oldQ;
            togPrev[d*2+c] = eff[2];
            mq[d][c]       = newQ;
            mchg[d][c]     = (newQ != oldQ);
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic [1:0] observed,
                              input logic [1:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic checkAll();
      checkOutput("q_a",   q0,   mq[0]);
      checkOutput("qn_a",  qn0,  ~mq[0]);
      checkOutput("chg_a", chg0, mchg[0]);
      checkOutput("q_b",   q1,   mq[1]);
      checkOutput("qn_b",  qn1,  ~mq[1]);
      checkOutput("chg_b", chg1, mchg[1]);
   endtask

   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         modelEdge();
         #1;
         checkAll();
      end
   endtask

   initial begin
      r     = 1'b0;
      on_n  = 2'b11;
      off_n = 2'b11;
      tog_n = 2'b11;
      modelReset();
      #12;
      $display("[TB] reset state");
      checkOutput("rst_q_a",   q0,   2'b11);
      checkOutput("rst_qn_a",  qn0,  2'b00);
      checkOutput("rst_chg_a", chg0, 2'b00);
      checkOutput("rst_q_b",   q1,   2'b10);
      r = 1'b1;
      applyStimulus(4);
      checkOutput("idle_hold_a", q0, 2'b11);

      $display("[TB] one-cycle off_n[0]");
      off_n = 2'b10;
      applyStimulus(1);
      off_n = 2'b11;
      applyStimulus(1);
      checkOutput("off_pre_a", q0, 2'b11);
      applyStimulus(1);
      checkOutput("off_q_a",   q0,   2'b10);
      checkOutput("off_chg_a", chg0, 2'b01);
      applyStimulus(1);
      checkOutput("off_chg_clr_a", chg0, 2'b00);

      $display("[TB] on_n[1] and off_n[1] together");
      on_n  = 2'b01;
      off_n = 2'b01;
      applyStimulus(5);
      on_n = 2'b11;
      applyStimulus(2);
      checkOutput("both_hold_a", q0, 2'b10);
      applyStimulus(1);
      checkOutput("both_rel_a", q0, 2'b00);
      off_n = 2'b11;
      applyStimulus(4);

      $display("[TB] toggle bursts");
      for (int k = 0; k < 4; k++) begin
         tog_n = 2'b00;
         applyStimulus(10);
         tog_n = 2'b11;
         applyStimulus(10);
         checkOutput("tog_seq_a", q0, {1'b0, (k % 2 == 0) ? 1'b1 : 1'b0});
      end

      $display("[TB] filtered off_n[0]");
      on_n = 2'b10;
      applyStimulus(6);
      on_n = 2'b11;
      applyStimulus(8);
      checkOutput("filt_set_b", {1'b0, q1[0]}, 2'b01);
      off_n = 2'b10;
      applyStimulus(3);
      off_n = 2'b11;
      applyStimulus(8);
      checkOutput("filt_glitch_b", {1'b0, q1[0]}, 2'b01);
      off_n = 2'b10;
      applyStimulus(5);
      checkOutput("filt_edge5_b", {1'b0, q1[0]}, 2'b01);
      off_n = 2'b11;
      applyStimulus(1);
      checkOutput("filt_edge6_b",   {1'b0, q1[0]},   2'b00);
      checkOutput("filt_chg6_b",    {1'b0, chg1[0]}, 2'b01);
      applyStimulus(8);

      $display("[TB] randomized traffic with asynchronous reset");
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < 2; c++) begin
            on_n[c]  = ($urandom_range(0, 11) != 0);
            off_n[c] = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 2) == 0) tog_n[c] = ~tog_n[c];
         end
         if (i == 200) begin
            #3;
            r = 1'b0;
            #1;
            modelReset();
            checkOutput("arst_q_a",   q0,   2'b11);
            checkOutput("arst_qn_a",  qn0,  2'b00);
            checkOutput("arst_chg_a", chg0, 2'b00);
            checkOutput("arst_q_b",   q1,   2'b10);
            checkOutput("arst_chg_b", chg1, 2'b00);
            #10;
            r = 1'b1;
         end
         applyStimulus(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
